bus_sequencer: RTL and testbench

//  Control-side counterpart of the dual-bus tri-state register file. Decodes a 10-bit

---
 rtl/bus_seq_pkg.sv | 24 ++
 rtl/onehot_dec.sv | 15 +
 rtl/bus_sequencer.sv | 157 +++++++++++++++
 tb/tb_bus_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// Shared types and instruction field positions for the bus sequencer.
// Opcode/state enums are shared by the RTL; the bench keeps its own model.
package bus_seq_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'h0,
    OP_MOV  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_NOP  = 4'h4
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2
  } state_e;

  localparam int unsigned OP_LSB = 6;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RX_LSB = 3;
  localparam int unsigned RY_LSB = 0;

endpackage

// File: rtl/onehot_dec.sv
// Register index to one-hot enable decoder; all zeros when disabled.
module onehot_dec #(
  parameter int unsigned RBITS = 3
) (
  input  logic                    i_en,
  input  logic [RBITS-1:0]        i_idx,
  output logic [(1<<RBITS)-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_sequencer.sv
// Instruction sequencer driving register, bus and ALU enables for the 10-bit datapath.
// Outputs are registered: each step's enables are computed one cycle ahead and flopped.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int unsigned W     = 10,
  parameter int unsigned RBITS = 3,
  localparam int unsigned NREG = 1 << RBITS
) (
  input  logic            CLKb,
  input  logic            RST,
  input  logic            Run,
  input  logic [W-1:0]    Instr,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout0,
  output logic [NREG-1:0] Rout1,
  output logic            ExtOut,
  output logic            Gin,
  output logic            Gout,
  output logic            AddSub,
  output logic            Busy,
  output logic            Done
);

  state_e          r_state, w_state_d;
  logic [W-1:0]    r_instr, w_instr_d;
  logic [W-1:0]    w_src;
  opcode_e         w_op;
  logic [RBITS-1:0] w_rx, w_ry;

  logic             w_rin_en, w_rout0_en, w_rout1_en;
  logic [RBITS-1:0] w_rin_idx, w_rout0_idx, w_rout1_idx;
  logic             w_ext, w_gin, w_gout, w_addsub, w_done;
  logic [NREG-1:0]  w_rin, w_rout0, w_rout1;

  logic [NREG-1:0]  r_rin, r_rout0, r_rout1;
  logic             r_ext, r_gin, r_gout, r_addsub, r_busy, r_done;

  // In IDLE the T1 step is decoded straight from Instr; later steps use the latched copy.
  assign w_src = (r_state == S_IDLE) ? Instr : r_instr;
  assign w_op  = opcode_e'(w_src[OP_LSB +: OP_W]);
  assign w_rx  = w_src[RX_LSB +: RBITS];
  assign w_ry  = w_src[RY_LSB +: RBITS];

  always_comb begin
    w_state_d   = r_state;
    w_instr_d   = r_instr;
    w_rin_en    = 1'b0;
    w_rout0_en  = 1'b0;
    w_rout1_en  = 1'b0;
    w_rin_idx   = w_rx;
    w_rout0_idx = w_rx;
    w_rout1_idx = w_ry;
    w_ext       = 1'b0;
    w_gin       = 1'b0;
    w_gout      = 1'b0;
    w_addsub    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Run) begin
          w_state_d = S_T1;
          w_instr_d = Instr;
          case (w_op)
            OP_LOAD: begin
              w_ext    = 1'b1;
              w_rin_en = 1'b1;
              w_done   = 1'b1;
            end
            OP_MOV: begin
              w_rout0_en  = 1'b1;
              w_rout0_idx = w_ry;
              w_rin_en    = 1'b1;
              w_done      = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              w_rout0_en = 1'b1;
              w_rout1_en = 1'b1;
              w_gin      = 1'b1;
              w_addsub   = (w_op == OP_SUB);
            end
            default: w_done = 1'b1;
          endcase
        end
      end
      S_T1: begin
        if (w_op == OP_ADD || w_op == OP_SUB) begin
          w_state_d = S_T2;
          w_gout    = 1'b1;
          w_rin_en  = 1'b1;
          w_done    = 1'b1;
        end else begin
          w_state_d = S_IDLE;
        end
      end
      S_T2:    w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  onehot_dec #(.RBITS(RBITS)) u_dec_rin (
    .i_en     (w_rin_en),
    .i_idx    (w_rin_idx),
    .o_onehot (w_rin)
  );

  onehot_dec #(.RBITS(RBITS)) u_dec_rout0 (
    .i_en     (w_rout0_en),
    .i_idx    (w_rout0_idx),
    .o_onehot (w_rout0)
  );

  onehot_dec #(.RBITS(RBITS)) u_dec_rout1 (
    .i_en     (w_rout1_en),
    .i_idx    (w_rout1_idx),
    .o_onehot (w_rout1)
  );

  always_ff @(posedge CLKb or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_rin    <= '0;
      r_rout0  <= '0;
      r_rout1  <= '0;
      r_ext    <= 1'b0;
      r_gin    <= 1'b0;
      r_gout   <= 1'b0;
      r_addsub <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_instr  <= w_instr_d;
      r_rin    <= w_rin;
      r_rout0  <= w_rout0;
      r_rout1  <= w_rout1;
      r_ext    <= w_ext;
      r_gin    <= w_gin;
      r_gout   <= w_gout;
      r_addsub <= w_addsub;
      r_busy   <= (w_state_d != S_IDLE);
      r_done   <= w_done;
    end
  end

  assign Rin    = r_rin;
  assign Rout0  = r_rout0;
  assign Rout1  = r_rout1;
  assign ExtOut = r_ext;
  assign Gin    = r_gin;
  assign Gout   = r_gout;
  assign AddSub = r_addsub;
  assign Busy   = r_busy;
  assign Done   = r_done;

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench: a reference model queues each accepted instruction's expected steps,
// and a monitor compares every cycle's outputs against the queue plus the bus invariants.
module tb_bus_sequencer;

  logic       CLKb, RST, Run;
  logic [9:0] Instr;
  logic [7:0] Rin, Rout0, Rout1;
  logic       ExtOut, Gin, Gout, AddSub, Busy, Done;

  bus_sequencer dut (
    .CLKb   (CLKb),
    .RST    (RST),
    .Run    (Run),
    .Instr  (Instr),
    .Rin    (Rin),
    .Rout0  (Rout0),
    .Rout1  (Rout1),
    .ExtOut (ExtOut),
    .Gin    (Gin),
    .Gout   (Gout),
    .AddSub (AddSub),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial begin
    CLKb = 1'b0;
    forever #5 CLKb = ~CLKb;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Expected output word: {Busy, Rin, Rout0, Rout1, ExtOut, Gin, Gout, AddSub, Done}
  logic [29:0] exp_q[$];
  int          m_left = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [29:0] outs();
    return {Busy, Rin, Rout0, Rout1, ExtOut, Gin, Gout, AddSub, Done};
  endfunction

  function automatic logic [29:0] step(input logic [7:0] rin, input logic [7:0] r0,
                                       input logic [7:0] r1, input logic ext,
                                       input logic gin, input logic gout,
                                       input logic sub, input logic done);
    return {1'b1, rin, r0, r1, ext, gin, gout, sub, done};
  endfunction

  // Reference semantics: list of per-cycle enable sets for one instruction.
  task automatic push_instr(input logic [9:0] ins);
    logic [3:0] op;
    logic [7:0] bx, by;
    op = ins[9:6];
    bx = 8'd1 << ins[5:3];
    by = 8'd1 << ins[2:0];
    case (op)
      4'h0: exp_q.push_back(step(bx, 8'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      4'h1: exp_q.push_back(step(bx, by, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      4'h2, 4'h3: begin
        exp_q.push_back(step(8'h0, bx, by, 1'b0, 1'b1, 1'b0, op == 4'h3, 1'b0));
        exp_q.push_back(step(bx, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      end
      default: exp_q.push_back(step(8'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endcase
    m_left = exp_q.size();
  endtask

  // Model: an instruction occupies as many cycles as it has steps, then Run is heard again.
  initial begin
    forever begin
      @(posedge CLKb or posedge RST);
      if (RST) begin
        exp_q.delete();
        m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
      end else if (Run) begin
        push_instr(Instr);
      end
    end
  end

  // Monitor
  initial begin
    logic prev_done;
    logic [29:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge CLKb);
      if (RST) begin
        chk("reset_outputs", outs(), 0);
        prev_done = 1'b0;
      end else begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("step", outs(), e);
        end else begin
          chk("idle_outputs", outs(), 0);
        end
        chk("onehot_rin", $onehot0(Rin), 1);
        chk("onehot_rout0", $onehot0(Rout0), 1);
        chk("onehot_rout1", $onehot0(Rout1), 1);
        chk("bus0_single_driver", (32'(|Rout0) + 32'(ExtOut) + 32'(Gout)) <= 1, 1);
        if (prev_done) chk("done_then_idle", Busy, 0);
        prev_done = Done;
      end
    end
  end

  logic [3:0] ops[7];

  initial begin
    RST   = 1'b1;
    Run   = 1'b0;
    Instr = '0;
    repeat (2) @(negedge CLKb);
    chk("reset_state", outs(), 0);
    RST = 1'b0;
    @(negedge CLKb);

    // LOAD R5
    Run = 1'b1; Instr = 10'h028;
    @(negedge CLKb);
    Run = 1'b0;
    chk("load_t1", {Rin, ExtOut, Done, Busy}, {8'h20, 1'b1, 1'b1, 1'b1});
    @(negedge CLKb);
    chk("load_after", outs(), 0);

    // MOV R2,R7
    Run = 1'b1; Instr = 10'h057;
    @(negedge CLKb);
    Run = 1'b0;
    chk("mov_t1", {Rout0, Rin, Done, ExtOut}, {8'h80, 8'h04, 1'b1, 1'b0});
    @(negedge CLKb);

    // SUB R1,R3
    Run = 1'b1; Instr = 10'h0CB;
    @(negedge CLKb);
    Run = 1'b0;
    chk("sub_t1", {Rout0, Rout1, Gin, AddSub, Done, Rin},
        {8'h02, 8'h08, 1'b1, 1'b1, 1'b0, 8'h00});
    @(negedge CLKb);
    chk("sub_t2", {Gout, Rin, Done, Gin}, {1'b1, 8'h02, 1'b1, 1'b0});
    @(negedge CLKb);

    // ADD R1,R3 interrupted by reset in T2
    Run = 1'b1; Instr = 10'h08B;
    @(negedge CLKb);
    Run = 1'b0;
    chk("add_t1", {Rout0, Rout1, Gin, AddSub}, {8'h02, 8'h08, 1'b1, 1'b0});
    @(posedge CLKb);
    #2 RST = 1'b1;
    #1 chk("reset_mid_add", outs(), 0);
    @(negedge CLKb);
    @(negedge CLKb);
    RST = 1'b0;
    @(negedge CLKb);
    chk("no_done_after_reset", {Done, Busy}, 0);

    // Run held: ADD R4,R1 then MOV R2,R7; Instr changes while busy
    Run = 1'b1; Instr = 10'h0A1;
    @(negedge CLKb);
    Instr = 10'h057;
    chk("b2b_add_t1", {Rout0, Rout1, Gin}, {8'h10, 8'h02, 1'b1});
    @(negedge CLKb);
    chk("b2b_add_t2", {Gout, Rin, Done}, {1'b1, 8'h10, 1'b1});
    @(negedge CLKb);
    chk("b2b_gap_idle", Busy, 0);
    @(negedge CLKb);
    Run = 1'b0;
    chk("b2b_mov_t1", {Rout0, Rin, Done}, {8'h80, 8'h04, 1'b1});
    @(negedge CLKb);

    // Random stream including undefined opcodes
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h3;
    ops[4] = 4'h4; ops[5] = 4'hF; ops[6] = 4'h9;
    for (int i = 0; i < 500; i++) begin
      Run   = ($urandom_range(0, 3) != 0);
      Instr = {ops[$urandom_range(0, 6)], 6'($urandom)};
      @(negedge CLKb);
    end

    // Explicit undefined opcode 4'hF
    Run = 1'b0;
    repeat (3) @(negedge CLKb);
    Run = 1'b1; Instr = 10'h3FF;
    @(negedge CLKb);
    Run = 1'b0;
    chk("opF_done_only", outs(), {1'b1, 24'h0, 5'b00001});
    repeat (4) @(negedge CLKb);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
